// File: rtl/mux_nto1_scan.sv
// rtl/mux_nto1_scan.sv - N-to-1 registered channel mux with manual select, auto-scan and hold
//
// Purpose: picks one WIDTH-bit channel out of a flat CHANNELS*WIDTH bus and
// registers it. In manual mode the channel comes from sel. In scan mode the
// channel steps through all channels, staying DWELL edges on each one. While
// hold is high, out, ch and the dwell counter do not change.
//
// Ports:
//   clock    in   rising-edge clock
//   resetn   in   asynchronous active-low reset
//   data_in  in   CHANNELS*WIDTH; channel k at [k*WIDTH +: WIDTH]
//   sel      in   SELW manual channel select
//   mode     in   0 = manual, 1 = auto-scan
//   hold     in   freeze out/ch/counter (takes priority over mode)
//   out      out  WIDTH registered data of the selected channel
//   ch       out  SELW registered index of the selected channel
//   switched out  one-cycle pulse on each edge where ch takes a new value
module mux_nto1_scan #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 4,
    parameter int DWELL    = 8,
    localparam int SELW    = $clog2(CHANNELS)
) (
    input  logic                      clock,
    input  logic                      resetn,
    input  logic [CHANNELS*WIDTH-1:0] data_in,
    input  logic [SELW-1:0]           sel,
    input  logic                      mode,
    input  logic                      hold,
    output logic [WIDTH-1:0]          out,
    output logic [SELW-1:0]           ch,
    output logic                      switched
);

    localparam int CNTW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(DWELL - 1);

    typedef enum logic [1:0] {
        ST_MANUAL = 2'd0,
        ST_SCAN   = 2'd1,
        ST_FROZEN = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d, cnt_cur;
    logic [SELW-1:0] ch_q, ch_d;
    logic [WIDTH-1:0] out_q;
    logic            switched_q;

    // The action of an edge is chosen by the inputs present at that edge,
    // so the next state is decoded straight from hold/mode.
    always_comb begin
        state_d = ST_MANUAL;
        cnt_d   = cnt_q;
        ch_d    = ch_q;
        cnt_cur = cnt_q;

        if (hold) begin
            state_d = ST_FROZEN;
        end else if (mode) begin
            state_d = ST_SCAN;
        end else begin
            state_d = ST_MANUAL;
        end

        case (state_d)
            ST_MANUAL: begin
                ch_d  = sel;
                cnt_d = '0;
            end
            ST_SCAN: begin
                // A scan entered from manual always starts a fresh dwell;
                // a scan resumed from a freeze keeps the frozen count.
                cnt_cur = (state_q == ST_MANUAL) ? '0 : cnt_q;
                if (cnt_cur == CNT_LAST) begin
                    cnt_d = '0;
                    ch_d  = ch_q + SELW'(1);   // power-of-two wrap is free
                end else begin
                    cnt_d = cnt_cur + CNTW'(1);
                end
            end
            default: begin
                cnt_d = cnt_q;
                ch_d  = ch_q;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_MANUAL;
            cnt_q      <= '0;
            ch_q       <= '0;
            out_q      <= '0;
            switched_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ch_q    <= ch_d;
            if (state_d == ST_FROZEN) begin
                switched_q <= 1'b0;
            end else begin
                // Index with the channel being loaded now so out and ch
                // always describe the same channel.
                out_q      <= data_in[ch_d*WIDTH +: WIDTH];
                switched_q <= (ch_d != ch_q);
            end
        end
    end

    assign out      = out_q;
    assign ch       = ch_q;
    assign switched = switched_q;

endmodule

// File: tb/tb_mux_nto1_scan.sv
// tb/tb_mux_nto1_scan.sv - self-checking bench for mux_nto1_scan
module tb_mux_nto1_scan;

    localparam int W = 4;
    localparam int N = 4;
    localparam int D = 8;

    logic         clock = 1'b0;
    logic         resetn = 1'b0;
    logic [N*W-1:0] data_in;
    logic [1:0]   sel;
    logic         mode;
    logic         hold;
    logic [W-1:0] out, out1;
    logic [1:0]   ch, ch1;
    logic         switched, switched1;

    int errors = 0;
    int checks = 0;

    // Reference model: channel = (origin + scan_edges / DWELL) mod N
    int           origin;
    int           t;
    int           mch;
    logic [W-1:0] mout;
    logic         msw;

    mux_nto1_scan #(.WIDTH(W), .CHANNELS(N), .DWELL(D)) u_dut (
        .clock(clock), .resetn(resetn), .data_in(data_in), .sel(sel),
        .mode(mode), .hold(hold), .out(out), .ch(ch), .switched(switched)
    );

    mux_nto1_scan #(.WIDTH(W), .CHANNELS(N), .DWELL(1)) u_dut1 (
        .clock(clock), .resetn(resetn), .data_in(data_in), .sel(sel),
        .mode(mode), .hold(hold), .out(out1), .ch(ch1), .switched(switched1)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        origin = 0;
        t      = 0;
        mch    = 0;
        mout   = '0;
        msw    = 1'b0;
    endtask

    task automatic model_edge();
        int prev;
        if (hold) begin
            msw = 1'b0;
        end else begin
            prev = mch;
            if (!mode) begin
                origin = int'(sel);
                t      = 0;
                mch    = int'(sel);
            end else begin
                t++;
                mch = (origin + t / D) % N;
            end
            mout = data_in[mch*W +: W];
            msw  = (mch != prev);
        end
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
        chk("out", 32'(out), 32'(mout));
        chk("ch", 32'(ch), 32'(mch));
        chk("switched", 32'(switched), 32'(msw));
    endtask

    initial begin
        int pulses;
        int prev1;
        data_in = {4'hD, 4'hC, 4'hB, 4'hA};
        sel  = 2'd0;
        mode = 1'b0;
        hold = 1'b0;
        model_reset();

        // Reset state before any edge
        #2;
        chk("rst_out", 32'(out), 32'h0);
        chk("rst_ch", 32'(ch), 32'h0);
        chk("rst_sw", 32'(switched), 32'h0);
        @(posedge clock);
        #1;
        resetn = 1'b1;

        // Manual select of channel 2
        sel = 2'd2;
        step();
        chk("man_out", 32'(out), 32'hC);
        chk("man_ch", 32'(ch), 32'd2);
        chk("man_sw", 32'(switched), 32'd1);
        step();
        chk("man_sw_hold", 32'(switched), 32'd0);

        // Full scan sweep from ch 0, counter 0
        sel = 2'd0;
        step();
        mode = 1'b1;
        pulses = 0;
        for (int k = 1; k <= 32; k++) begin
            step();
            chk("scan_seq", 32'(ch), 32'((k / 8) % 4));
            if (switched) pulses++;
        end
        chk("scan_pulses", 32'(pulses), 32'd4);

        // Hold for 3 edges at counter 5
        for (int k = 0; k < 5; k++) step();
        hold = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("hold_ch", 32'(ch), 32'd0);
            chk("hold_sw", 32'(switched), 32'd0);
        end
        hold = 1'b0;
        step();
        step();
        chk("hold_resume", 32'(ch), 32'd0);
        step();
        chk("hold_adv", 32'(ch), 32'd1);

        // Hold on terminal count at ch 3
        for (int k = 0; k < 23; k++) step();
        chk("wrap_pre", 32'(ch), 32'd3);
        hold = 1'b1;
        step();
        chk("wrap_hold", 32'(ch), 32'd3);
        hold = 1'b0;
        step();
        chk("wrap_ch", 32'(ch), 32'd0);
        chk("wrap_out", 32'(out), 32'hA);
        chk("wrap_sw", 32'(switched), 32'd1);

        // Async reset while scanning on ch 2
        for (int k = 0; k < 19; k++) step();
        chk("ar_pre", 32'(ch), 32'd2);
        #3;
        resetn = 1'b0;
        #1;
        chk("ar_out", 32'(out), 32'h0);
        chk("ar_ch", 32'(ch), 32'h0);
        chk("ar_sw", 32'(switched), 32'h0);
        model_reset();
        @(posedge clock);
        #1;
        chk("ar_held", 32'(ch), 32'h0);
        resetn = 1'b1;
        step();

        // Data follow on manual channel 1
        mode = 1'b0;
        sel  = 2'd1;
        step();
        step();
        data_in[1*W +: W] = 4'hE;
        step();
        chk("follow_out", 32'(out), 32'hE);
        chk("follow_sw", 32'(switched), 32'd0);

        // DWELL=1 instance advances every scan edge
        mode = 1'b1;
        step();
        for (int k = 0; k < 8; k++) begin
            prev1 = int'(ch1);
            step();
            chk("d1_ch", 32'(ch1), 32'((prev1 + 1) % N));
            chk("d1_sw", 32'(switched1), 32'd1);
            chk("d1_out", 32'(out1), 32'(data_in[int'(ch1)*W +: W]));
        end

        // Randomized mode/hold/sel/data against the model
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 3) == 0) data_in = N*W'($urandom);
            sel  = 2'($urandom_range(0, 3));
            mode = ($urandom_range(0, 5) != 0);
            hold = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 15) == 0) mode = 1'b0;
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
